// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative multiply/divide unit.
// The unit drives busy/done/result/tag_out; the pipeline drives everything else.
interface muldiv_unit_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
);
    logic             start;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [TAG_W-1:0] tag_in;
    logic             flush;
    logic             busy;
    logic             done;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output start, funct3, a, b, tag_in, flush,
        input  busy, done, result, tag_out
    );

    modport slave (
        input  start, funct3, a, b, tag_in, flush,
        output busy, done, result, tag_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide, one bit/cycle.
// Define MULDIV_FASTPATH_EN to retire divide-by-zero, signed overflow and zero-operand multiplies early.
module muldiv_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input logic          clk,
    input logic          reset,
    muldiv_unit_if.slave bus
);

    localparam int unsigned CntW = $clog2(XLEN);

    localparam logic [2:0] OpMul    = 3'b000;
    localparam logic [2:0] OpMulh   = 3'b001;
    localparam logic [2:0] OpMulhsu = 3'b010;
    localparam logic [2:0] OpMulhu  = 3'b011;
    localparam logic [2:0] OpDiv    = 3'b100;
    localparam logic [2:0] OpDivu   = 3'b101;
    localparam logic [2:0] OpRem    = 3'b110;

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]  hi_q, hi_d;      // product high word / partial remainder
    logic [XLEN-1:0]  lo_q, lo_d;      // multiplier then product low word / dividend then quotient
    logic [XLEN-1:0]  opb_q, opb_d;    // multiplicand / divisor magnitude
    logic [2:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [TAG_W-1:0] tag_out_q, tag_out_d;
    logic             done_q, done_d;

    logic             a_signed, b_signed, a_neg, b_neg, sign_in;
    logic [XLEN-1:0]  mag_a, mag_b;
    logic [XLEN:0]    mul_sum, trial;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]  quo_fix, rem_fix, fix_val;

    assign a_signed = (bus.funct3 == OpMulh) || (bus.funct3 == OpMulhsu) ||
                      (bus.funct3 == OpDiv)  || (bus.funct3 == OpRem);
    assign b_signed = (bus.funct3 == OpMulh) || (bus.funct3 == OpDiv) || (bus.funct3 == OpRem);
    assign a_neg    = a_signed && bus.a[XLEN-1];
    assign b_neg    = b_signed && bus.b[XLEN-1];
    assign mag_a    = a_neg ? -bus.a : bus.a;
    assign mag_b    = b_neg ? -bus.b : bus.b;

    // A zero divisor must leave the all-ones quotient un-negated.
    always_comb begin
        sign_in = 1'b0;
        case (bus.funct3)
            OpMulh:   sign_in = a_neg ^ b_neg;
            OpMulhsu: sign_in = a_neg;
            OpDiv:    sign_in = (a_neg ^ b_neg) && (bus.b != '0);
            OpRem:    sign_in = a_neg;
            default:  sign_in = 1'b0;
        endcase
    end

`ifdef MULDIV_FASTPATH_EN
    logic ovf, fast_path;
    assign ovf       = ((bus.funct3 == OpDiv) || (bus.funct3 == OpRem)) &&
                       (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);
    assign fast_path = bus.funct3[2] ? ((bus.b == '0) || ovf) : ((bus.a == '0) || (bus.b == '0));
`endif

    assign mul_sum  = {1'b0, hi_q} + {1'b0, opb_q & {XLEN{lo_q[0]}}};
    assign trial    = {hi_q, lo_q[XLEN-1]} - {1'b0, opb_q};
    assign prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    assign quo_fix  = neg_q ? -lo_q : lo_q;
    assign rem_fix  = neg_q ? -hi_q : hi_q;

    always_comb begin
        fix_val = rem_fix;
        case (op_q)
            OpMul:                     fix_val = prod_fix[XLEN-1:0];
            OpMulh, OpMulhsu, OpMulhu: fix_val = prod_fix[2*XLEN-1:XLEN];
            OpDiv, OpDivu:             fix_val = quo_fix;
            default:                   fix_val = rem_fix;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opb_d     = opb_q;
        op_d      = op_q;
        neg_d     = neg_q;
        tag_d     = tag_q;
        result_d  = result_q;
        tag_out_d = tag_out_q;
        done_d    = 1'b0;

        if (bus.flush) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    // The done cycle still blocks a new request.
                    if (bus.start && !done_q) begin
                        hi_d    = '0;
                        lo_d    = mag_a;
                        opb_d   = mag_b;
                        op_d    = bus.funct3;
                        neg_d   = sign_in;
                        tag_d   = bus.tag_in;
                        cnt_d   = CntW'(XLEN - 1);
                        state_d = StCalc;
`ifdef MULDIV_FASTPATH_EN
                        if (fast_path) begin
                            state_d = StFix;
                            if (!bus.funct3[2]) begin
                                lo_d = '0;
                            end else if (bus.b == '0) begin
                                lo_d = '1;
                                hi_d = mag_a;
                            end
                        end
`endif
                    end
                end
                StCalc: begin
                    if (op_q[2]) begin
                        if (!trial[XLEN]) begin
                            hi_d = trial[XLEN-1:0];
                            lo_d = {lo_q[XLEN-2:0], 1'b1};
                        end else begin
                            hi_d = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
                            lo_d = {lo_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        {hi_d, lo_d} = {mul_sum, lo_q[XLEN-1:1]};
                    end
                    if (cnt_q == '0) begin
                        state_d = StFix;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                StFix: begin
                    result_d  = fix_val;
                    tag_out_d = tag_q;
                    done_d    = 1'b1;
                    state_d   = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            opb_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            tag_q     <= '0;
            result_q  <= '0;
            tag_out_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opb_q     <= opb_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            tag_q     <= tag_d;
            result_q  <= result_d;
            tag_out_q <= tag_out_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy    = (state_q != StIdle);
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.tag_out = tag_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (XLEN=32): expectations queued at issue, checked on done.
// Honours MULDIV_FASTPATH_EN when choosing expected latencies.
module tb_muldiv_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 5;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    localparam int SLOW_LAT = XLEN + 1;
`ifdef MULDIV_FASTPATH_EN
    localparam int FAST_LAT = 1;
`else
    localparam int FAST_LAT = XLEN + 1;
`endif

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          id;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   next_id  = 0;
    logic [31:0] last_res = '0;
    logic [4:0]  last_tag = '0;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    muldiv_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Scoreboard: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: result=%h tag=%0d, required no done", bus.result,
                         bus.tag_out);
            end else begin
                mon_e = sb.pop_front();
                last_res = mon_e.res;
                last_tag = mon_e.tag;
                if (bus.result !== mon_e.res || bus.tag_out !== mon_e.tag) begin
                    n_fail++;
                    $display("FAIL result_op%0d: got %h tag %0d, required %h tag %0d", mon_e.id,
                             bus.result, bus.tag_out, mon_e.res, mon_e.tag);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] ea, eb, p;
        logic [31:0] q, r;
        ea = (op == MULH || op == MULHSU) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (op == MULH) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        if (b == 32'd0) begin
            q = '1;
            r = a;
        end else if (op[1:0] == 2'b00 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = '0;
        end else if (op == DIV || op == REM) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        case (op)
            MUL:                 return p[31:0];
            MULH, MULHSU, MULHU: return p[63:32];
            DIV, DIVU:           return q;
            default:             return r;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        bit special;
        if (op[2]) begin
            special = (b == 32'd0) ||
                      (op[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        end else begin
            special = (a == 32'd0) || (b == 32'd0);
        end
        return special ? FAST_LAT : SLOW_LAT;
    endfunction

    task automatic push_exp(input logic [31:0] res, input logic [4:0] tag);
        sb.push_back('{res: res, tag: tag, id: next_id});
        next_id++;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        bus.funct3 = op;
        bus.a      = a;
        bus.b      = b;
        bus.tag_in = tag;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_vectors(input vec_t v[$], input string name);
        int cyc;
        foreach (v[i]) begin
            push_exp(v[i].res, 5'(i + 1));
            issue(v[i].op, v[i].a, v[i].b, 5'(i + 1));
            wait_done(cyc);
            n_checks++;
            if (cyc !== v[i].lat) begin
                n_fail++;
                $display("FAIL %s_latency[%0d]: got %0d cycles, required %0d", name, i, cyc,
                         v[i].lat);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'd0 ||
            bus.tag_out !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b result=%h tag=%0d, required 0 0 0 0",
                     bus.busy, bus.done, bus.result, bus.tag_out);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul();
        vec_t v[$];
        int   cyc;
        // Plan example with its tag of 9 checked by the scoreboard.
        push_exp(32'hFFFF_FFFB, 5'd9);
        issue(MUL, 32'hFFFF_FFFF, 32'd5, 5'd9);
        wait_done(cyc);
        n_checks++;
        if (cyc !== SLOW_LAT) begin
            n_fail++;
            $display("FAIL mul_latency: got %0d cycles, required %0d", cyc, SLOW_LAT);
        end
        @(negedge clk);
        v.push_back('{op: MULHU,  a: 32'hFFFF_FFFF, b: 32'd5, res: 32'h0000_0004, lat: SLOW_LAT});
        v.push_back('{op: MULH,   a: 32'hFFFF_FFFF, b: 32'd5, res: 32'hFFFF_FFFF, lat: SLOW_LAT});
        v.push_back('{op: MULHSU, a: 32'hFFFF_FFFF, b: 32'd5, res: 32'hFFFF_FFFF, lat: SLOW_LAT});
        v.push_back('{op: MUL,    a: 32'd7,  b: 32'd6,        res: 32'd42,        lat: SLOW_LAT});
        v.push_back('{op: MULHU,  a: 32'h8000_0000, b: 32'h8000_0000, res: 32'h4000_0000,
                      lat: SLOW_LAT});
        v.push_back('{op: MUL,    a: 32'd0,  b: 32'h1234,     res: 32'd0,         lat: FAST_LAT});
        v.push_back('{op: MULH,   a: 32'hDEAD_BEEF, b: 32'd0, res: 32'd0,         lat: FAST_LAT});
        run_vectors(v, "mul");
    endtask

    task automatic test_div();
        vec_t v[$];
        v.push_back('{op: DIV,  a: 32'hFFFF_FFF9, b: 32'd2, res: 32'hFFFF_FFFD, lat: SLOW_LAT});
        v.push_back('{op: REM,  a: 32'hFFFF_FFF9, b: 32'd2, res: 32'hFFFF_FFFF, lat: SLOW_LAT});
        v.push_back('{op: DIVU, a: 32'd100, b: 32'd7,       res: 32'd14,        lat: SLOW_LAT});
        v.push_back('{op: REMU, a: 32'd100, b: 32'd7,       res: 32'd2,         lat: SLOW_LAT});
        v.push_back('{op: DIV,  a: 32'd7,   b: 32'hFFFF_FFFE, res: 32'hFFFF_FFFD, lat: SLOW_LAT});
        v.push_back('{op: REM,  a: 32'd7,   b: 32'hFFFF_FFFE, res: 32'd1,       lat: SLOW_LAT});
        v.push_back('{op: DIVU, a: 32'hFFFF_FFFF, b: 32'd1, res: 32'hFFFF_FFFF, lat: SLOW_LAT});
        run_vectors(v, "div");
    endtask

    task automatic test_special();
        vec_t v[$];
        v.push_back('{op: DIV,  a: 32'h8000_0000, b: 32'hFFFF_FFFF, res: 32'h8000_0000,
                      lat: FAST_LAT});
        v.push_back('{op: REM,  a: 32'h8000_0000, b: 32'hFFFF_FFFF, res: 32'd0, lat: FAST_LAT});
        v.push_back('{op: DIVU, a: 32'h1234, b: 32'd0, res: 32'hFFFF_FFFF, lat: FAST_LAT});
        v.push_back('{op: REMU, a: 32'h1234, b: 32'd0, res: 32'h1234,      lat: FAST_LAT});
        v.push_back('{op: DIV,  a: 32'hFFFF_FFFB, b: 32'd0, res: 32'hFFFF_FFFF, lat: FAST_LAT});
        v.push_back('{op: REM,  a: 32'hFFFF_FFFB, b: 32'd0, res: 32'hFFFF_FFFB, lat: FAST_LAT});
        run_vectors(v, "special");
    endtask

    task automatic test_busy_ignore();
        int cyc;
        push_exp(32'd14, 5'd3);
        issue(DIVU, 32'd100, 32'd7, 5'd3);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            // Competing request with different operands while busy.
            bus.start  = (cyc >= 5 && cyc < 9);
            bus.funct3 = MUL;
            bus.a      = 32'd3;
            bus.b      = 32'd3;
            bus.tag_in = 5'd7;
        end
        bus.start = 1'b0;
        n_checks++;
        if (cyc !== SLOW_LAT) begin
            n_fail++;
            $display("FAIL busy_ignore_latency: got %0d cycles, required %0d", cyc, SLOW_LAT);
        end
        // Request raised in the done cycle must be refused.
        bus.start = 1'b1;
        bus.funct3 = MUL;
        bus.a = 32'd2;
        bus.b = 32'd3;
        bus.tag_in = 5'd4;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_in_done_cycle: busy=%b, required 0", bus.busy);
        end
        bus.funct3 = REMU;
        bus.a = 32'd100;
        bus.b = 32'd7;
        bus.tag_in = 5'd5;
        push_exp(32'd2, 5'd5);
        @(negedge clk);
        bus.start = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_after_done: busy=%b, required 1", bus.busy);
        end
        wait_done(cyc);
        n_checks++;
        if (cyc !== SLOW_LAT) begin
            n_fail++;
            $display("FAIL back_to_back_latency: got %0d cycles, required %0d", cyc, SLOW_LAT);
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        int dones;
        issue(DIV, 32'hFFFF_FFF9, 32'd2, 5'd6);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_busy: busy=%b, required 0", bus.busy);
        end
        n_checks++;
        if (bus.result !== last_res || bus.tag_out !== last_tag) begin
            n_fail++;
            $display("FAIL flush_hold: result=%h tag=%0d, required %h tag %0d", bus.result,
                     bus.tag_out, last_res, last_tag);
        end
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL flush_no_done: %0d done pulses, required 0", dones);
        end
        // flush outranks a simultaneous start.
        bus.funct3 = MUL;
        bus.a = 32'd3;
        bus.b = 32'd3;
        bus.tag_in = 5'd8;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_vs_start: busy=%b, required 0", bus.busy);
        end
        repeat (40) @(negedge clk);
    endtask

    task automatic test_random();
        int cyc;
        int lat;
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 16; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            if (i == 3) a = 32'd0;
            lat = exp_lat(op, a, b);
            push_exp(model(op, a, b), 5'(i + 10));
            issue(op, a, b, 5'(i + 10));
            wait_done(cyc);
            n_checks++;
            if (cyc !== lat) begin
                n_fail++;
                $display("FAIL random_latency[%0d]: got %0d cycles, required %0d", i, cyc, lat);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midop();
        int dones;
        issue(MUL, 32'd7, 32'd6, 5'd1);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'd0 ||
            bus.tag_out !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_midop: busy=%b done=%b result=%h tag=%0d, required 0 0 0 0",
                     bus.busy, bus.done, bus.result, bus.tag_out);
        end
        @(negedge clk);
        reset = 1'b1;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL reset_no_done: %0d done pulses, required 0", dones);
        end
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = 3'b000;
        bus.a      = '0;
        bus.b      = '0;
        bus.tag_in = '0;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_busy_ignore();
        test_flush();
        test_random();
        test_reset_midop();
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
